// File: rtl/bcd_pkg.sv
// Shared types and helpers for the two-digit BCD run counter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_NINE = 4'd9;

  function automatic logic is_valid_bcd(input bcd_t d);
    return d <= BCD_NINE;
  endfunction

endpackage

// File: rtl/bcd_run_counter_if.sv
// Control inputs and display/cascade outputs of the BCD run counter.
interface bcd_run_counter_if;
  logic       cnt_en;
  logic       start_stop;
  logic       clear;
  logic       up_dn;
  logic       load;
  logic [7:0] load_val;
  logic [3:0] bcd_hi;
  logic [3:0] bcd_lo;
  logic       carry;
  logic       running;
  logic       load_err;

  modport master (
    output cnt_en, start_stop, clear, up_dn, load, load_val,
    input  bcd_hi, bcd_lo, carry, running, load_err
  );

  modport slave (
    input  cnt_en, start_stop, clear, up_dn, load, load_val,
    output bcd_hi, bcd_lo, carry, running, load_err
  );
endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD digit: clear/load/step with a runtime wrap value; wrap flags the
// digit sitting at the boundary for the current direction.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic ld,
  input  bcd_t ld_val,
  input  logic step,
  input  logic up,
  input  bcd_t max,
  output bcd_t digit,
  output logic wrap
);

  assign wrap = up ? (digit == max) : (digit == '0);

  always_ff @(posedge clk) begin
    if (rst)       digit <= '0;
    else if (clr)  digit <= '0;
    else if (ld)   digit <= ld_val;
    else if (step) begin
      if (wrap) digit <= up ? '0 : max;
      else      digit <= up ? digit + 4'd1 : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_run_counter.sv
// Two-digit BCD up/down counter with run/pause/clear/load FSM.
// Define BCD_RUN_COUNTER_SATURATE_EN to hold at the boundary instead of wrapping.
module bcd_run_counter
  import bcd_pkg::*;
#(
  parameter int MAX_HI = 5,
  parameter int MAX_LO = 9
) (
  input  logic         clk,
  input  logic         rst,
  bcd_run_counter_if.slave bus
);

  localparam bcd_t TOP_HI = bcd_t'(MAX_HI);
  localparam bcd_t TOP_LO = bcd_t'(MAX_LO);

  state_e state, state_nxt;
  logic   start_stop_d, start_edge;
  bcd_t   hi, lo, lo_max;
  logic   hi_wrap, lo_wrap, terminal;
  logic   step, step_digits;
  logic   load_ok, load_take, load_rej;
  logic   carry, load_err;

  assign start_edge = bus.start_stop & ~start_stop_d;

  assign load_ok   = is_valid_bcd(bus.load_val[7:4]) && is_valid_bcd(bus.load_val[3:0])
                     && (bus.load_val <= {TOP_HI, TOP_LO});
  assign load_take = bus.load & ~bus.clear & (state != RUN) & load_ok;
  assign load_rej  = bus.load & ~bus.clear & ~load_take;

  // A load request, accepted or not, pre-empts a step in the same cycle.
  assign step     = (state == RUN) & bus.cnt_en & ~bus.clear & ~bus.load;
  assign terminal = hi_wrap & lo_wrap;

`ifdef BCD_RUN_COUNTER_SATURATE_EN
  assign step_digits = step & ~terminal;
`else
  assign step_digits = step;
`endif

  // Ones boundary depends on the tens digit: counting up it is the terminal
  // ones value when tens is at max; counting down it reloads MAX_LO on 00.
  assign lo_max = bus.up_dn ? ((hi == TOP_HI) ? TOP_LO : BCD_NINE)
                            : ((hi == '0)     ? TOP_LO : BCD_NINE);

  bcd_digit_cell u_lo (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clear),
    .ld    (load_take),
    .ld_val(bus.load_val[3:0]),
    .step  (step_digits),
    .up    (bus.up_dn),
    .max   (lo_max),
    .digit (lo),
    .wrap  (lo_wrap)
  );

  bcd_digit_cell u_hi (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clear),
    .ld    (load_take),
    .ld_val(bus.load_val[7:4]),
    .step  (step_digits & lo_wrap),
    .up    (bus.up_dn),
    .max   (TOP_HI),
    .digit (hi),
    .wrap  (hi_wrap)
  );

  always_comb begin
    state_nxt = state;
    if (bus.clear) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:  if (start_edge) state_nxt = RUN;
        RUN: begin
          if (start_edge) state_nxt = PAUSE;
`ifdef BCD_RUN_COUNTER_SATURATE_EN
          else if (step && terminal) state_nxt = PAUSE;
`endif
        end
        PAUSE: if (start_edge) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      start_stop_d <= 1'b0;
      carry        <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      state        <= state_nxt;
      start_stop_d <= bus.start_stop;
      carry        <= step & terminal;
      load_err     <= load_rej;
    end
  end

  assign bus.bcd_hi   = hi;
  assign bus.bcd_lo   = lo;
  assign bus.carry    = carry;
  assign bus.running  = (state == RUN);
  assign bus.load_err = load_err;

endmodule

// File: tb/tb_bcd_run_counter.sv
// Scoreboard bench: stimulus updates an integer-count reference model and
// queues the expected outputs; a monitor compares them after each clock edge.
module tb_bcd_run_counter;
  localparam int MAX_HI = 5;
  localparam int MAX_LO = 9;
  localparam int MODN   = MAX_HI * 10 + MAX_LO + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_run_counter_if bus();

  bcd_run_counter #(.MAX_HI(MAX_HI), .MAX_LO(MAX_LO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int hi;
    int lo;
    bit carry;
    bit running;
    bit lerr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: count as a plain integer 0..MODN-1, mode 0 idle/1 run/2 paused.
  int m_cnt  = 0;
  int m_mode = 0;
  bit m_ss   = 0;
  bit ss_lvl = 0;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  task automatic cycle(input bit r, input bit en, input bit ss, input bit clr,
                       input bit up, input bit ld, input logic [7:0] lv);
    exp_t e;
    bit   edge_s, valid;
    int   hv, lvv, nmode;
    @(negedge clk);
    rst            = r;
    bus.cnt_en     = en;
    bus.start_stop = ss;
    bus.clear      = clr;
    bus.up_dn      = up;
    bus.load       = ld;
    bus.load_val   = lv;
    e.carry = 0;
    e.lerr  = 0;
    edge_s  = ss && !m_ss;
    m_ss    = ss;
    if (r) begin
      m_cnt = 0; m_mode = 0; m_ss = 0;
    end else if (clr) begin
      m_cnt = 0; m_mode = 0;
    end else begin
      nmode = m_mode;
      if (edge_s) nmode = (m_mode == 1) ? 2 : 1;
      if (ld) begin
        hv    = int'(lv[7:4]);
        lvv   = int'(lv[3:0]);
        valid = (hv <= 9) && (lvv <= 9) && (hv * 10 + lvv < MODN);
        if (m_mode != 1 && valid) m_cnt = hv * 10 + lvv;
        else e.lerr = 1;
      end else if (m_mode == 1 && en) begin
        if (up ? (m_cnt == MODN - 1) : (m_cnt == 0)) begin
          e.carry = 1;
`ifdef BCD_RUN_COUNTER_SATURATE_EN
          nmode = 2;
`else
          m_cnt = up ? 0 : MODN - 1;
`endif
        end else begin
          m_cnt = up ? m_cnt + 1 : m_cnt - 1;
        end
      end
      m_mode = nmode;
    end
    e.hi      = m_cnt / 10;
    e.lo      = m_cnt % 10;
    e.running = (m_mode == 1);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, ss_lvl, 0, 1, 0, 8'h00);
  endtask

  task automatic press();
    ss_lvl = 1; idle(1);
    ss_lvl = 0; idle(1);
  endtask

  task automatic strobe(input bit up);
    cycle(0, 1, ss_lvl, 0, up, 0, 8'h00);
    idle(1);
  endtask

  task automatic do_load(input logic [7:0] v);
    cycle(0, 0, ss_lvl, 0, 1, 1, v);
    idle(1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("bcd_hi",   int'(bus.bcd_hi),   e.hi);
        chk("bcd_lo",   int'(bus.bcd_lo),   e.lo);
        chk("carry",    int'(bus.carry),    int'(e.carry));
        chk("running",  int'(bus.running),  int'(e.running));
        chk("load_err", int'(bus.load_err), int'(e.lerr));
      end
    end
  end

  initial begin : stim
    bit         r, en, clr, up, ld;
    logic [7:0] lv;
    rst = 1'b1;
    bus.cnt_en = 0; bus.start_stop = 0; bus.clear = 0;
    bus.up_dn = 1; bus.load = 0; bus.load_val = 8'h00;

    cycle(1, 0, 0, 0, 1, 0, 8'h00);
    cycle(1, 0, 0, 0, 1, 0, 8'h00);
    idle(1);

    // Full up lap with a single carry on the wrap to 00.
    press();
    for (int i = 0; i < 60; i++) strobe(1);

    // Step and pause in the same cycle at 07.
    for (int i = 0; i < 7; i++) strobe(1);
    cycle(0, 1, 1, 0, 1, 0, 8'h00);
    ss_lvl = 0; idle(1);
    for (int i = 0; i < 5; i++) strobe(1);

    // Loads while paused: one good, two rejected, plus boundary values.
    do_load(8'h42);
    do_load(8'h6A);
    do_load(8'h61);
    do_load(8'h59);
    do_load(8'h60);

    // Down wrap from 00.
    do_load(8'h00);
    press();
    strobe(0);
    strobe(0);
    do_load(8'h10);  // rejected while running

    // Clear beats load and step.
    press();
    do_load(8'h33);
    press();
    cycle(0, 1, 0, 1, 1, 1, 8'h12);
    idle(1);

    // Reset mid-count.
    do_load(8'h16);
    press();
    strobe(1);
    cycle(1, 0, 0, 0, 1, 0, 8'h00);
    idle(1);

`ifdef BCD_RUN_COUNTER_SATURATE_EN
    do_load(8'h58);
    press();
    for (int i = 0; i < 3; i++) strobe(1);
    idle(2);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 9) == 0) ss_lvl = ~ss_lvl;
      clr = ($urandom_range(0, 99) == 0);
      up  = ($urandom_range(0, 3) != 0);
      ld  = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 1) == 1)
        lv = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
      else
        lv = 8'($urandom);
      cycle(r, en, ss_lvl, clr, up, ld, lv);
    end

    idle(1);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
